// File: rtl/axil_instr_pkg.sv
// Shared constants and types for the AXI4-Lite instruction register slave.
// No logic, no latency, no backpressure; holds response codes, word type and index sizing.
// Used by axil_instr_regfile and axil_instr_slave.
package axil_instr_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [31:0] instr_word_t;

  // Register index width; a single register still needs a 1-bit index.
  function automatic int idx_width(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/axil_instr_regfile.sv
// Instruction register storage with byte-strobe merge, async read mux and write pulses.
// Write visible one cycle after wr_en; instr_wr pulses for exactly that following cycle.
// No backpressure: every wr_en cycle commits.
module axil_instr_regfile
  import axil_instr_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int IDX_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_idx,
  input  instr_word_t              wr_data,
  input  logic [3:0]               wr_strb,
  input  logic [IDX_W-1:0]         rd_idx,
  output instr_word_t              rd_data,
  output logic [32*NUM_REGS-1:0]   instr_q,
  output logic [NUM_REGS-1:0]      instr_wr
);

  instr_word_t             regs_q [NUM_REGS];
  instr_word_t             regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]     instr_wr_q;
  logic [NUM_REGS-1:0]     instr_wr_d;

  always_comb begin
    regs_d     = regs_q;
    instr_wr_d = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (wr_en && (int'(wr_idx) == k)) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_strb[b]) begin
            regs_d[k][8*b +: 8] = wr_data[8*b +: 8];
          end
        end
        instr_wr_d[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= '0;
      end
      instr_wr_q <= '0;
    end else begin
      regs_q     <= regs_d;
      instr_wr_q <= instr_wr_d;
    end
  end

  // Reads see the pre-commit value, which gives read-before-write on a shared edge.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (int'(rd_idx) == k) begin
        rd_data = regs_q[k];
      end
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign instr_q[32*k +: 32] = regs_q[k];
  end

  assign instr_wr = instr_wr_q;

endmodule

// File: rtl/axil_instr_slave.sv
// AXI4-Lite slave over a bank of instruction registers; optional SLVERR via AXIL_INSTR_SLVERR_EN.
// Write commits on the edge both AW and W are present, BVALID/RVALID one cycle after handshake.
// One write and one read outstanding; AW/W/AR stall while BVALID/RVALID wait for BREADY/RREADY.
module axil_instr_slave
  import axil_instr_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_REGS           = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [32*NUM_REGS-1:0]          instr_q,
  output logic [NUM_REGS-1:0]             instr_wr
);

  localparam int IDX_W  = idx_width(NUM_REGS);
  localparam int FULL_W = C_S_AXI_ADDR_WIDTH - 2;

  logic                          aw_held_q, aw_held_d;
  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic                          w_held_q, w_held_d;
  instr_word_t                   wdata_q, wdata_d;
  logic [3:0]                    wstrb_q, wstrb_d;
  logic                          bvalid_q, bvalid_d;
  logic [1:0]                    bresp_q, bresp_d;
  logic                          rvalid_q, rvalid_d;
  instr_word_t                   rdata_q, rdata_d;
  logic [1:0]                    rresp_q, rresp_d;

  logic                          aw_hs, w_hs, ar_hs, commit, wr_en;
  logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr;
  instr_word_t                   wr_data, rd_data;
  logic [3:0]                    wr_strb;
  logic [FULL_W-1:0]             wr_full_idx, rd_full_idx;
  logic                          wr_in_range, rd_in_range;

  assign S_AXI_AWREADY = ARESETN & ~aw_held_q & ~bvalid_q;
  assign S_AXI_WREADY  = ARESETN & ~w_held_q & ~bvalid_q;
  assign S_AXI_ARREADY = ARESETN & ~rvalid_q;

  assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
  assign commit = (aw_held_q | aw_hs) & (w_held_q | w_hs);

  // A held beat wins; otherwise the live beat handshaking this cycle is used.
  assign wr_addr = aw_held_q ? awaddr_q : S_AXI_AWADDR;
  assign wr_data = w_held_q ? wdata_q : S_AXI_WDATA;
  assign wr_strb = w_held_q ? wstrb_q : S_AXI_WSTRB;

  assign wr_full_idx = wr_addr[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_full_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

`ifdef AXIL_INSTR_SLVERR_EN
  assign wr_in_range = (int'(wr_full_idx) < NUM_REGS);
  assign rd_in_range = (int'(rd_full_idx) < NUM_REGS);
`else
  assign wr_in_range = 1'b1;
  assign rd_in_range = 1'b1;
`endif

  always_comb begin
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    wr_en     = 1'b0;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = S_AXI_AWADDR;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = S_AXI_WDATA;
      wstrb_d  = S_AXI_WSTRB;
    end
    if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_in_range ? RESP_OKAY : RESP_SLVERR;
      wr_en     = wr_in_range;
    end
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_in_range ? rd_data : '0;
      rresp_d  = rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_held_q <= 1'b0;
      awaddr_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      aw_held_q <= aw_held_d;
      awaddr_q  <= awaddr_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  axil_instr_regfile #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .wr_en    (wr_en),
    .wr_idx   (wr_full_idx[IDX_W-1:0]),
    .wr_data  (wr_data),
    .wr_strb  (wr_strb),
    .rd_idx   (rd_full_idx[IDX_W-1:0]),
    .rd_data  (rd_data),
    .instr_q  (instr_q),
    .instr_wr (instr_wr)
  );

  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RDATA  = rdata_q;
  assign S_AXI_RRESP  = rresp_q;

  // Protection bits and sub-word address bits carry no meaning for this register bank.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr, S_AXI_ARADDR};

endmodule
